// File: rtl/intr_cond_sync.sv
// Multi-channel interrupt synchroniser and conditioner: per-channel level or rising-edge-latched
// pending state, masking, stretched edge pulses and a sticky overflow flag.
module intr_cond_sync #(
  parameter int unsigned INTR_WIDTH     = 8,
  parameter int unsigned SYNC_STAGE     = 2,
  parameter int unsigned STRETCH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INTR_WIDTH-1:0] async_intr,
  input  logic [INTR_WIDTH-1:0] mode_edge,
  input  logic [INTR_WIDTH-1:0] intr_mask,
  input  logic [INTR_WIDTH-1:0] intr_clr,
  output logic [INTR_WIDTH-1:0] intr_pending,
  output logic [INTR_WIDTH-1:0] intr_out,
  output logic [INTR_WIDTH-1:0] intr_pulse,
  output logic [INTR_WIDTH-1:0] intr_ovf,
  output logic                  intr_any
);

  localparam int unsigned    CntW    = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(STRETCH_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  (* ASYNC_REG = "TRUE" *) logic [INTR_WIDTH-1:0] r_sync [SYNC_STAGE];

  logic [INTR_WIDTH-1:0] r_prev;
  logic [INTR_WIDTH-1:0] r_pending;
  logic [INTR_WIDTH-1:0] r_ovf;
  logic [CntW-1:0]       r_cnt [INTR_WIDTH];

  logic [INTR_WIDTH-1:0] w_sync_lvl;
  logic [INTR_WIDTH-1:0] w_rise;
  logic [INTR_WIDTH-1:0] w_pending_d;
  logic [INTR_WIDTH-1:0] w_ovf_d;
  logic [INTR_WIDTH-1:0] w_load;
  logic [INTR_WIDTH-1:0] w_pulse;
  logic [CntW-1:0]       w_cnt_d [INTR_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < SYNC_STAGE; j++) begin
        r_sync[j] <= '0;
      end
    end else begin
      r_sync[0] <= async_intr;
      for (int unsigned j = 1; j < SYNC_STAGE; j++) begin
        r_sync[j] <= r_sync[j-1];
      end
    end
  end

  assign w_sync_lvl = r_sync[SYNC_STAGE-1];
  assign w_rise     = w_sync_lvl & ~r_prev;

  // In edge mode a rise wins over a coincident clear; a clear also masks a new overflow.
  always_comb begin
    w_pending_d = (mode_edge & (w_rise | (r_pending & ~intr_clr)))
                | (~mode_edge & w_sync_lvl);
    w_ovf_d     = (mode_edge & ((w_rise & r_pending & ~intr_clr) | (r_ovf & ~intr_clr)))
                | (~mode_edge & r_ovf);
  end

  assign w_load = w_rise & mode_edge & intr_mask;

  always_comb begin
    for (int unsigned i = 0; i < INTR_WIDTH; i++) begin
      w_cnt_d[i] = r_cnt[i];
      w_pulse[i] = (r_cnt[i] != '0);
      if (w_load[i]) begin
        w_cnt_d[i] = CntLoad;
      end else if (r_cnt[i] != '0) begin
        w_cnt_d[i] = r_cnt[i] - CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
      for (int unsigned i = 0; i < INTR_WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_prev    <= w_sync_lvl;
      r_pending <= w_pending_d;
      r_ovf     <= w_ovf_d;
      for (int unsigned i = 0; i < INTR_WIDTH; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign intr_pending = r_pending;
  assign intr_out     = r_pending & intr_mask;
  assign intr_pulse   = w_pulse;
  assign intr_ovf     = r_ovf;
  assign intr_any     = |intr_out;

endmodule

// File: tb/tb_intr_cond_sync.sv
// Bench for intr_cond_sync: three parameterisations checked every cycle against a
// history-based reference model, plus directed literal checks.
module tb_intr_cond_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] drv_a [3];
  logic [63:0] drv_md[3];
  logic [63:0] drv_mk[3];
  logic [63:0] drv_cl[3];

  int total = 0;
  int bad   = 0;

  int c_w [3] = '{8, 1, 33};
  int c_s [3] = '{2, 3, 3};
  int c_sc[3] = '{4, 1, 1};

  wire [7:0]  p0, o0, pu0, ov0;
  wire        any0;
  wire [0:0]  p1, o1, pu1, ov1;
  wire        any1;
  wire [32:0] p2, o2, pu2, ov2;
  wire        any2;

  intr_cond_sync #(.INTR_WIDTH(8), .SYNC_STAGE(2), .STRETCH_CYCLES(4)) u_dut0 (
    .clk(clk), .rst(rst), .async_intr(drv_a[0][7:0]), .mode_edge(drv_md[0][7:0]),
    .intr_mask(drv_mk[0][7:0]), .intr_clr(drv_cl[0][7:0]), .intr_pending(p0),
    .intr_out(o0), .intr_pulse(pu0), .intr_ovf(ov0), .intr_any(any0)
  );

  intr_cond_sync #(.INTR_WIDTH(1), .SYNC_STAGE(3), .STRETCH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .async_intr(drv_a[1][0:0]), .mode_edge(drv_md[1][0:0]),
    .intr_mask(drv_mk[1][0:0]), .intr_clr(drv_cl[1][0:0]), .intr_pending(p1),
    .intr_out(o1), .intr_pulse(pu1), .intr_ovf(ov1), .intr_any(any1)
  );

  intr_cond_sync #(.INTR_WIDTH(33), .SYNC_STAGE(3), .STRETCH_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .async_intr(drv_a[2][32:0]), .mode_edge(drv_md[2][32:0]),
    .intr_mask(drv_mk[2][32:0]), .intr_clr(drv_cl[2][32:0]), .intr_pending(p2),
    .intr_out(o2), .intr_pulse(pu2), .intr_ovf(ov2), .intr_any(any2)
  );

  logic [63:0] ap[3], ao[3], apu[3], aov[3];
  logic        aany[3];
  assign ap[0] = 64'(p0);  assign ao[0] = 64'(o0);  assign apu[0] = 64'(pu0);
  assign aov[0] = 64'(ov0); assign aany[0] = any0;
  assign ap[1] = 64'(p1);  assign ao[1] = 64'(o1);  assign apu[1] = 64'(pu1);
  assign aov[1] = 64'(ov1); assign aany[1] = any1;
  assign ap[2] = 64'(p2);  assign ao[2] = 64'(o2);  assign apu[2] = 64'(pu2);
  assign aov[2] = 64'(ov2); assign aany[2] = any2;

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference model: m_hist[k][j] holds the input sampled j+1 edges ago, so the synchronised
  // level seen by the conditioner is simply the sample from SYNC_STAGE edges back.
  int          cyc     = 0;
  bit          started = 1'b0;
  logic [63:0] m_hist[3][8];
  logic [63:0] m_pend[3];
  logic [63:0] m_ovf [3];
  int          m_last[3][64];

  always @(posedge clk) begin : model
    logic [63:0] s, pv, rise, wm, pn, on;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      wm = wmask(c_w[k]);
      if (rst) begin
        for (int j = 0; j < 8; j++) m_hist[k][j] = '0;
        m_pend[k] = '0;
        m_ovf[k]  = '0;
        for (int i = 0; i < 64; i++) m_last[k][i] = -1000;
      end else begin
        s    = m_hist[k][c_s[k]-1];
        pv   = m_hist[k][c_s[k]];
        rise = s & ~pv;
        pn = (drv_md[k] & (rise | (m_pend[k] & ~drv_cl[k]))) | (~drv_md[k] & s);
        on = (drv_md[k] & ((rise & m_pend[k] & ~drv_cl[k]) | (m_ovf[k] & ~drv_cl[k])))
           | (~drv_md[k] & m_ovf[k]);
        for (int i = 0; i < c_w[k]; i++) begin
          if (rise[i] && drv_md[k][i] && drv_mk[k][i]) m_last[k][i] = cyc;
        end
        for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = drv_a[k] & wm;
        m_pend[k] = pn & wm;
        m_ovf[k]  = on & wm;
      end
    end
    started = 1'b1;
  end

  task automatic cmp(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp(nm, 0, act, exp);
  endtask

  always @(negedge clk) begin : compare
    logic [63:0] ep, wm, eo;
    #2;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        wm = wmask(c_w[k]);
        ep = '0;
        for (int i = 0; i < c_w[k]; i++) ep[i] = ((cyc - m_last[k][i]) < c_sc[k]);
        eo = m_pend[k] & drv_mk[k] & wm;
        cmp("m_pending", k, ap[k], m_pend[k]);
        cmp("m_out", k, ao[k], eo);
        cmp("m_pulse", k, apu[k], ep);
        cmp("m_ovf", k, aov[k], m_ovf[k]);
        cmp("m_any", k, 64'(aany[k]), 64'(|eo));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      drv_a[k] = '0; drv_md[k] = '0; drv_mk[k] = '0; drv_cl[k] = '0;
    end
    drv_a[0] = 64'hFF; drv_md[0] = 64'hFF; drv_mk[0] = 64'hFF;
    rst = 1'b1;

    // Reset held for three edges with all inputs high.
    tick(3);
    chk("rst_pending", 64'(p0), 64'h0);
    chk("rst_out", 64'(o0), 64'h0);
    chk("rst_pulse", 64'(pu0), 64'h0);
    chk("rst_ovf", 64'(ov0), 64'h0);
    chk("rst_any", 64'(any0), 64'h0);
    rst = 1'b0;
    tick(1); chk("rel_pend_e1", 64'(p0), 64'h00);
    tick(1); chk("rel_pend_e2", 64'(p0), 64'h00);
    tick(1); chk("rel_pend_e3", 64'(p0), 64'hFF);
    drv_a[0] = '0;
    tick(4);
    drv_cl[0] = 64'hFF; tick(1); drv_cl[0] = '0; tick(1);
    chk("clrall_pend", 64'(p0), 64'h0);
    chk("clrall_pulse", 64'(pu0), 64'h0);

    // Edge latch / clear on channel 2.
    drv_a[0][2] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick(1);
      chk("edge_pend2", 64'(p0[2]), 64'(j >= 2));
      chk("edge_pulse2", 64'(pu0[2]), 64'(j >= 2 && j <= 5));
    end
    drv_a[0][2] = 1'b0;
    tick(5);
    chk("edge_hold2", 64'(p0[2]), 64'd1);
    drv_cl[0][2] = 1'b1; tick(1); drv_cl[0][2] = 1'b0;
    chk("edge_clr2", 64'(p0[2]), 64'd0);

    // Overflow then rise/clear collision on channel 0.
    drv_a[0][0] = 1'b1; tick(3); drv_a[0][0] = 1'b0; tick(3);
    drv_a[0][0] = 1'b1; tick(3);
    chk("ovf0_set", 64'(ov0[0]), 64'd1);
    chk("ovf0_pend", 64'(p0[0]), 64'd1);
    drv_a[0][0] = 1'b0; tick(3);
    drv_a[0][0] = 1'b1; tick(2);
    drv_cl[0][0] = 1'b1; tick(1); drv_cl[0][0] = 1'b0;
    chk("coll0_pend", 64'(p0[0]), 64'd1);
    chk("coll0_ovf", 64'(ov0[0]), 64'd0);
    drv_a[0][0] = 1'b0; tick(3);
    drv_cl[0][0] = 1'b1; tick(1); drv_cl[0][0] = 1'b0;
    chk("coll0_clr", 64'(p0[0]), 64'd0);

    // Level mode on channel 5: 10-cycle input, clear held throughout.
    drv_md[0][5] = 1'b0;
    tick(1);
    drv_a[0][5] = 1'b1; drv_cl[0][5] = 1'b1;
    for (int j = 0; j < 15; j++) begin
      tick(1);
      chk("lvl_pend5", 64'(p0[5]), 64'(j >= 2 && j <= 11));
      chk("lvl_pulse5", 64'(pu0[5]), 64'd0);
      if (j == 9) drv_a[0][5] = 1'b0;
    end
    drv_cl[0][5] = 1'b0; drv_md[0][5] = 1'b1;

    // Mask and retrigger on channel 7.
    drv_mk[0][7] = 1'b0;
    drv_a[0][7] = 1'b1; tick(3);
    chk("msk_pend7", 64'(p0[7]), 64'd1);
    chk("msk_out7", 64'(o0[7]), 64'd0);
    chk("msk_any", 64'(any0), 64'd0);
    chk("msk_pulse7", 64'(pu0[7]), 64'd0);
    drv_mk[0][7] = 1'b1; #1;
    chk("unmsk_out7", 64'(o0[7]), 64'd1);
    chk("unmsk_any", 64'(any0), 64'd1);
    drv_a[0][7] = 1'b0; tick(3);
    drv_cl[0][7] = 1'b1; tick(1); drv_cl[0][7] = 1'b0;
    drv_a[0][7] = 1'b1; tick(1);
    drv_a[0][7] = 1'b0; tick(1);
    drv_a[0][7] = 1'b1; tick(1);
    drv_a[0][7] = 1'b0;
    chk("retrig_pulse7", 64'(pu0[7]), 64'd1);
    for (int j = 3; j < 10; j++) begin
      tick(1);
      chk("retrig_pulse7", 64'(pu0[7]), 64'(j <= 7));
    end

    // Single-channel, three-stage instance: 4-edge latency, 1-cycle pulse.
    drv_md[1] = 64'd1; drv_mk[1] = 64'd1; tick(5);
    drv_a[1] = 64'd1;
    for (int j = 0; j < 5; j++) begin
      tick(1);
      cmp("s3_pend", 1, ap[1], 64'(j >= 3));
      cmp("s3_pulse", 1, apu[1], 64'(j == 3));
    end

    // Randomised phase across all three instances.
    for (int n = 0; n < 3000; n++) begin
      tick(1);
      for (int k = 0; k < 3; k++) begin
        logic [63:0] wm;
        wm = wmask(c_w[k]);
        drv_a[k] = (drv_a[k] ^ (rand64() & rand64() & rand64())) & wm;
        if ($urandom_range(0, 19) == 0) drv_md[k] = rand64() & wm;
        if ($urandom_range(0, 9) == 0)  drv_mk[k] = rand64() & wm;
        drv_cl[k] = ($urandom_range(0, 3) == 0) ? (rand64() & rand64() & wm) : '0;
      end
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
